tt_sweep_ctrl: RTL and testbench

Sequencer that exhaustively exercises a small combinational function block (N_IN inputs, one output) in hardware. It drives every input combination in ascending order and waits a programmable settle time before sampling the output. The sampled results are assembled into a truth table and compared against an expected table. It sits beside the function block in the exercise tops and replaces hand-written stimulus lists for on-board self-check.

---
 rtl/tt_sweep_ctrl_pkg.sv | 21 ++
 rtl/tt_sweep_ctrl_if.sv | 30 +++
 rtl/tt_sweep_ctrl_settle.sv | 35 +++
 rtl/tt_sweep_ctrl.sv | 124 ++++++++++++
 tb/tb_tt_sweep_ctrl.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/tt_sweep_ctrl_pkg.sv
// Shared types and constants for the truth-table sweep controller.
package tt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } tt_state_e;

    function automatic int tt_w(input int n_in);
        return 1 << n_in;
    endfunction

    localparam int TT_N_IN_DEF = 3;
    localparam int TT_W_DEF    = tt_w(TT_N_IN_DEF);

    // y = a'b'c' + ab'c' + ab'c
    localparam logic [7:0] SILLY_TT = 8'h31;

endpackage

// File: rtl/tt_sweep_ctrl_if.sv
// Control/result bundle between the sweep controller and its user.
interface tt_sweep_ctrl_if
    import tt_pkg::*;
#(
    parameter int N_IN = 3
);
    localparam int TT_W = tt_w(N_IN);

    logic            start;
    logic            abort;
    logic [TT_W-1:0] expected;
    logic            y_in;
    logic [N_IN-1:0] in_vec;
    logic            busy;
    logic            done;
    logic [TT_W-1:0] table_out;
    logic [TT_W-1:0] mismatch;
    logic            pass;

    modport master (
        output start, abort, expected, y_in,
        input  in_vec, busy, done, table_out, mismatch, pass
    );

    modport slave (
        input  start, abort, expected, y_in,
        output in_vec, busy, done, table_out, mismatch, pass
    );

endinterface

// File: rtl/tt_sweep_ctrl_settle.sv
// Settle timer: loads SETTLE, counts down, flags the last settle cycle.
module tt_settle_timer #(
    parameter int SETTLE = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic dec_i,
    output logic expire_o
);
    localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CW'(SETTLE);
        end else if (dec_i && cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // With no settle time every cycle is the sampling cycle.
    assign expire_o = (SETTLE == 0) || (cnt_q == CW'(1));

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Walks every input vector of a function block and builds its truth table.
module tt_sweep_ctrl
    import tt_pkg::*;
#(
    parameter int N_IN   = 3,
    parameter int SETTLE = 1
) (
    input logic            clk,
    input logic            reset_n,
    tt_sweep_ctrl_if.slave bus
);
    localparam int TT_W = tt_w(N_IN);
    localparam int IW   = N_IN + 1;

    tt_state_e       state_q;
    logic [IW-1:0]   idx_q;
    logic [IW-1:0]   idx_nxt;
    logic [N_IN-1:0] in_vec_q;
    logic            busy_q;
    logic            done_q;
    logic [TT_W-1:0] exp_q;
    logic [TT_W-1:0] table_q;
    logic [TT_W-1:0] tbl_nxt;
    logic [TT_W-1:0] mism_q;
    logic            pass_q;
    logic            last;
    logic            expire;
    logic            t_load;
    logic            t_dec;

    assign idx_nxt = idx_q + IW'(1);
    assign last    = (idx_q == IW'(TT_W - 1));

    always_comb begin
        tbl_nxt = table_q;
        tbl_nxt[idx_q[N_IN-1:0]] = bus.y_in;
    end

    assign t_load = ((state_q == ST_IDLE) && bus.start)
                 || ((state_q == ST_SAMPLE) && !bus.abort && !last);
    assign t_dec  = (state_q == ST_SETTLE) && !expire;

    tt_settle_timer #(
        .SETTLE(SETTLE)
    ) u_timer (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .load_i  (t_load),
        .dec_i   (t_dec),
        .expire_o(expire)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            in_vec_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            exp_q    <= '0;
            table_q  <= '0;
            mism_q   <= '0;
            pass_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        exp_q    <= bus.expected;
                        table_q  <= '0;
                        mism_q   <= '0;
                        pass_q   <= 1'b0;
                        idx_q    <= '0;
                        in_vec_q <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (bus.abort) begin
                        in_vec_q <= '0;
                        busy_q   <= 1'b0;
                        state_q  <= ST_IDLE;
                    end else if (expire) begin
                        state_q <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    if (bus.abort) begin
                        in_vec_q <= '0;
                        busy_q   <= 1'b0;
                        state_q  <= ST_IDLE;
                    end else if (last) begin
                        // Results are registered so they are valid alongside done.
                        table_q <= tbl_nxt;
                        mism_q  <= tbl_nxt ^ exp_q;
                        pass_q  <= ((tbl_nxt ^ exp_q) == '0);
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        table_q  <= tbl_nxt;
                        idx_q    <= idx_nxt;
                        in_vec_q <= idx_nxt[N_IN-1:0];
                        state_q  <= (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;
                    end
                end
                ST_DONE: begin
                    in_vec_q <= '0;
                    busy_q   <= 1'b0;
                    state_q  <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_vec    = in_vec_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.table_out = table_q;
    assign bus.mismatch  = mism_q;
    assign bus.pass      = pass_q;

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Scoreboard bench for tt_sweep_ctrl with SETTLE=1 and SETTLE=0 instances.
module tb_tt_sweep_ctrl;
    import tt_pkg::*;

    localparam int N = 3;
    localparam int W = 8;

    typedef struct {
        logic [W-1:0] tbl;
        logic [W-1:0] mis;
        logic         pas;
        int           lat;
        int           acc;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    tt_sweep_ctrl_if #(.N_IN(N)) b1 ();
    tt_sweep_ctrl_if #(.N_IN(N)) b0 ();

    tt_sweep_ctrl #(.N_IN(N), .SETTLE(1)) u_s1 (
        .clk(clk), .reset_n(reset_n), .bus(b1.slave)
    );
    tt_sweep_ctrl #(.N_IN(N), .SETTLE(0)) u_s0 (
        .clk(clk), .reset_n(reset_n), .bus(b0.slave)
    );

    logic [W-1:0] fn1 = '0;
    logic [W-1:0] fn0 = '0;
    assign b1.y_in = fn1[b1.in_vec];
    assign b0.y_in = fn0[b0.in_vec];

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   act1 = 0, acc1 = 0;
    int   act0 = 0, acc0 = 0;
    exp_t q1[$];
    exp_t q0[$];
    exp_t e1, e0, last1, last0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Monitors: pop on done, otherwise track the expected vector position.
    always @(negedge clk) if (reset_n) begin
        if (b1.done) begin
            chk("s1_done_expected", 32'(q1.size() > 0), 32'd1);
            if (q1.size() > 0) begin
                e1 = q1.pop_front();
                chk("s1_done_cycle", 32'(cyc - e1.acc), 32'(e1.lat));
                chk("s1_table", 32'(b1.table_out), 32'(e1.tbl));
                chk("s1_mismatch", 32'(b1.mismatch), 32'(e1.mis));
                chk("s1_pass", 32'(b1.pass), 32'(e1.pas));
                chk("s1_busy_in_done", 32'(b1.busy), 32'd1);
            end
            act1 = 0;
        end else if (act1 != 0 && b1.busy) begin
            chk("s1_in_vec", 32'(b1.in_vec), 32'((cyc - acc1 - 1) / 2));
        end
    end

    always @(negedge clk) if (reset_n) begin
        if (b0.done) begin
            chk("s0_done_expected", 32'(q0.size() > 0), 32'd1);
            if (q0.size() > 0) begin
                e0 = q0.pop_front();
                chk("s0_done_cycle", 32'(cyc - e0.acc), 32'(e0.lat));
                chk("s0_table", 32'(b0.table_out), 32'(e0.tbl));
                chk("s0_mismatch", 32'(b0.mismatch), 32'(e0.mis));
                chk("s0_pass", 32'(b0.pass), 32'(e0.pas));
            end
            act0 = 0;
        end else if (act0 != 0 && b0.busy) begin
            chk("s0_in_vec", 32'(b0.in_vec), 32'(cyc - acc0 - 1));
        end
    end

    // Reference: a full sweep reads back fn itself; done lands after 8*(S+1)+1 cycles.
    task automatic sweep(input int s, input logic [W-1:0] fn,
                         input logic [W-1:0] ex, input logic ab);
        exp_t x;
        x.tbl = fn;
        x.mis = fn ^ ex;
        x.pas = ((fn ^ ex) == '0);
        x.acc = cyc;
        if (s == 1) begin
            x.lat = W * 2 + 1;
            fn1 = fn; b1.expected = ex; b1.start = 1'b1; b1.abort = ab;
            q1.push_back(x); last1 = x; acc1 = cyc; act1 = 1;
            @(negedge clk);
            b1.start = 1'b0; b1.abort = 1'b0;
        end else begin
            x.lat = W + 1;
            fn0 = fn; b0.expected = ex; b0.start = 1'b1; b0.abort = ab;
            q0.push_back(x); last0 = x; acc0 = cyc; act0 = 1;
            @(negedge clk);
            b0.start = 1'b0; b0.abort = 1'b0;
        end
    endtask

    task automatic wait_done(input int s);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((s == 1) ? (act1 == 0) : (act0 == 0)) break;
        end
        chk("sweep_timeout", 32'((s == 1) ? act1 : act0), 32'd0);
        @(negedge clk);
    endtask

    task automatic hold_chk(input int s, input int n);
        for (int i = 0; i < n; i++) begin
            if (s == 1) begin
                chk("s1_hold_table", 32'(b1.table_out), 32'(last1.tbl));
                chk("s1_hold_mis", 32'(b1.mismatch), 32'(last1.mis));
                chk("s1_hold_pass", 32'(b1.pass), 32'(last1.pas));
                chk("s1_idle_busy", 32'(b1.busy), 32'd0);
                chk("s1_idle_vec", 32'(b1.in_vec), 32'd0);
            end else begin
                chk("s0_hold_table", 32'(b0.table_out), 32'(last0.tbl));
                chk("s0_hold_pass", 32'(b0.pass), 32'(last0.pas));
                chk("s0_idle_busy", 32'(b0.busy), 32'd0);
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_vec1(input logic [N-1:0] v);
        for (int i = 0; i < 40; i++) begin
            if (b1.in_vec == v) break;
            @(negedge clk);
        end
        chk("s1_reach_vec", 32'(b1.in_vec), 32'(v));
    endtask

    task automatic chk_zero1(input string nm);
        chk({nm, "_vec"}, 32'(b1.in_vec), 32'd0);
        chk({nm, "_busy"}, 32'(b1.busy), 32'd0);
        chk({nm, "_done"}, 32'(b1.done), 32'd0);
        chk({nm, "_table"}, 32'(b1.table_out), 32'd0);
        chk({nm, "_mis"}, 32'(b1.mismatch), 32'd0);
        chk({nm, "_pass"}, 32'(b1.pass), 32'd0);
    endtask

    logic [W-1:0] r, ex;

    initial begin
        b1.start = 0; b1.abort = 0; b1.expected = '0;
        b0.start = 0; b0.abort = 0; b0.expected = '0;

        #2 reset_n = 1'b0;
        #1 chk_zero1("reset");
        chk("reset_s0_busy", 32'(b0.busy), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        sweep(1, SILLY_TT, SILLY_TT, 1'b0);
        wait_done(1);
        hold_chk(1, 2);

        sweep(1, 8'h00, SILLY_TT, 1'b0);
        wait_done(1);
        hold_chk(1, 5);

        sweep(0, SILLY_TT, SILLY_TT, 1'b0);
        wait_done(0);
        hold_chk(0, 3);

        // start and abort together in IDLE: the sweep must still run
        sweep(1, SILLY_TT, SILLY_TT, 1'b1);
        wait_done(1);

        // re-pulsed start is ignored, abort at vector 3 drops the sweep
        sweep(1, SILLY_TT, SILLY_TT, 1'b0);
        wait_vec1(3'd2);
        b1.start = 1'b1;
        @(negedge clk);
        b1.start = 1'b0;
        wait_vec1(3'd3);
        b1.abort = 1'b1;
        void'(q1.pop_back());
        act1 = 0;
        @(negedge clk);
        b1.abort = 1'b0;
        chk("abort_busy", 32'(b1.busy), 32'd0);
        chk("abort_vec", 32'(b1.in_vec), 32'd0);
        chk("abort_done", 32'(b1.done), 32'd0);
        chk("abort_partial", 32'(b1.table_out), 32'(SILLY_TT & 8'h07));
        chk("abort_mis", 32'(b1.mismatch), 32'd0);
        chk("abort_pass", 32'(b1.pass), 32'd0);
        repeat (20) @(negedge clk);
        sweep(1, SILLY_TT, SILLY_TT, 1'b0);
        wait_done(1);

        for (int i = 0; i < 8; i++) begin
            r  = W'($urandom);
            ex = (i % 2 == 0) ? r : (r ^ W'(1 << $urandom_range(7, 0)));
            sweep(i % 2, r, ex, 1'b0);
            wait_done(i % 2);
        end

        // asynchronous reset in the middle of a sweep
        sweep(1, W'($urandom), SILLY_TT, 1'b0);
        wait_vec1(3'd5);
        void'(q1.pop_back());
        act1 = 0;
        #2 reset_n = 1'b0;
        #1 chk_zero1("midreset");
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (i % 8 == 0) chk_zero1("post_reset");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
